// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU front-end: field widths, flag bit
// positions, ALUControl encodings and the arbiter state type.
package alu_pkg;

    localparam int ALU_CTRL_W  = 3;
    localparam int ALU_SHIFT_W = 2;
    localparam int ALU_FLAG_W  = 4;

    // ALUFlags bit order is {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_ORR = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester that was not served
// last wins; a lone requester always wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one combinational ALU between two requesters: round-robin issue,
// registered operands, registered result/flag capture and one-hot responses.
module alu_arbiter #(
    parameter int WIDTH   = 5,
    parameter int CTRL_W  = alu_pkg::ALU_CTRL_W,
    parameter int SHIFT_W = alu_pkg::ALU_SHIFT_W,
    parameter int FLAG_W  = alu_pkg::ALU_FLAG_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [CTRL_W-1:0]  req0_ctrl,
    input  logic [SHIFT_W-1:0] req0_bshift,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic [CTRL_W-1:0]  req1_ctrl,
    input  logic [SHIFT_W-1:0] req1_bshift,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [FLAG_W-1:0]  rsp_flags,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic [SHIFT_W-1:0] alu_bshift,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [FLAG_W-1:0]  alu_flags
);

    import alu_pkg::*;

    state_t               r_state;
    logic                 r_last_grant;
    logic                 r_owner;
    logic [1:0]           r_rsp_valid;
    logic [WIDTH-1:0]     r_rsp_result;
    logic [FLAG_W-1:0]    r_rsp_flags;
    logic [WIDTH-1:0]     r_alu_a;
    logic [WIDTH-1:0]     r_alu_b;
    logic [CTRL_W-1:0]    r_alu_ctrl;
    logic [SHIFT_W-1:0]   r_alu_bshift;

    logic [1:0]           w_grant;
    logic                 w_gnt_idx;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_sel_a;
    logic [WIDTH-1:0]     w_sel_b;
    logic [CTRL_W-1:0]    w_sel_ctrl;
    logic [SHIFT_W-1:0]   w_sel_bshift;

    rr_arbiter2 u_rr (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // Grant is only offered while idle; EXEC/RESP keep both requesters stalled.
    assign req_ready = (r_state == IDLE) ? w_grant : 2'b00;
    assign w_accept  = (r_state == IDLE) && ((req_valid & w_grant) != 2'b00);
    assign w_gnt_idx = w_grant[1];

    assign w_sel_a      = w_gnt_idx ? req1_a      : req0_a;
    assign w_sel_b      = w_gnt_idx ? req1_b      : req0_b;
    assign w_sel_ctrl   = w_gnt_idx ? req1_ctrl   : req0_ctrl;
    assign w_sel_bshift = w_gnt_idx ? req1_bshift : req0_bshift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
            r_alu_bshift <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_a      <= w_sel_a;
                        r_alu_b      <= w_sel_b;
                        r_alu_ctrl   <= w_sel_ctrl;
                        r_alu_bshift <= w_sel_bshift;
                        r_owner      <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable for a full cycle; sample the ALU.
                    r_rsp_result <= alu_result;
                    r_rsp_flags  <= alu_flags;
                    r_rsp_valid  <= {r_owner, ~r_owner};
                    r_state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= 2'b00;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_ctrl   = r_alu_ctrl;
    assign alu_bshift = r_alu_bshift;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* side.
module tb_alu_arbiter;

    localparam int WIDTH = 5;

    logic       clk;
    logic       reset_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [4:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_ctrl, req1_ctrl;
    logic [1:0] req0_bshift, req1_bshift;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [4:0] rsp_result;
    logic [3:0] rsp_flags;
    logic [4:0] alu_a, alu_b;
    logic [2:0] alu_ctrl;
    logic [1:0] alu_bshift;
    logic [4:0] alu_result;
    logic [3:0] alu_flags;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(3), .SHIFT_W(2), .FLAG_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl), .req0_bshift(req0_bshift),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl), .req1_bshift(req1_bshift),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_bshift(alu_bshift),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: b is shifted left by bshift, flags are {N,Z,C,V}.
    logic [4:0] m_bs;
    logic [5:0] m_sum;
    logic       m_c, m_v;
    always_comb begin
        m_bs       = alu_b << alu_bshift;
        m_sum      = 6'd0;
        m_c        = 1'b0;
        m_v        = 1'b0;
        alu_result = 5'd0;
        case (alu_ctrl)
            3'b000: begin
                m_sum      = {1'b0, alu_a} + {1'b0, m_bs};
                alu_result = m_sum[4:0];
                m_c        = m_sum[5];
                m_v        = (alu_a[4] == m_bs[4]) && (m_sum[4] != alu_a[4]);
            end
            3'b001: begin
                m_sum      = {1'b0, alu_a} + {1'b0, ~m_bs} + 6'd1;
                alu_result = m_sum[4:0];
                m_c        = m_sum[5];
                m_v        = (alu_a[4] != m_bs[4]) && (m_sum[4] != alu_a[4]);
            end
            3'b010:  alu_result = alu_a & m_bs;
            3'b011:  alu_result = alu_a | m_bs;
            default: alu_result = alu_a ^ m_bs;
        endcase
        alu_flags = {alu_result[4], (alu_result == 5'd0), m_c, m_v};
    end

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req0_a = 5'd0; req0_b = 5'd0; req0_ctrl = 3'd0; req0_bshift = 2'd0;
        req1_a = 5'd0; req1_b = 5'd0; req1_ctrl = 3'd0; req1_bshift = 2'd0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_ctrl, alu_bshift, rsp_result, rsp_flags, rsp_valid} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%0d b=%0d ctrl=%0d sh=%0d res=%0d fl=%b rv=%b, want all 0",
                     alu_a, alu_b, alu_ctrl, alu_bshift, rsp_result, rsp_flags, rsp_valid);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: req_ready=%b rsp_valid=%b, want 00 00", req_ready, rsp_valid);
        end
    endtask

    task automatic test_single_op();
        @(negedge clk);
        req0_a = 5'd3; req0_b = 5'd5; req0_ctrl = 3'b000; req0_bshift = 2'd1;
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL single_grant: req_ready=%b want 01", req_ready);
        end
        @(negedge clk);                   // cycle 1: EXEC
        req_valid = 2'b00;
        #1;
        checks++;
        if (alu_a !== 5'd3 || alu_b !== 5'd5 || alu_ctrl !== 3'b000 || alu_bshift !== 2'd1) begin
            errors++;
            $display("FAIL single_issue: a=%0d b=%0d ctrl=%0d sh=%0d want 3 5 0 1", alu_a, alu_b, alu_ctrl, alu_bshift);
        end
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL single_exec: req_ready=%b rsp_valid=%b want 00 00", req_ready, rsp_valid);
        end
        @(negedge clk); #1;               // cycle 2: RESP
        checks++;
        if (rsp_valid !== 2'b01 || rsp_result !== 5'd13 || rsp_flags !== 4'b0000 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL single_resp: rv=%b res=%0d fl=%b rr=%b want 01 13 0000 00", rsp_valid, rsp_result, rsp_flags, req_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL single_done: rsp_valid=%b want 00", rsp_valid);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        req0_a = 5'd7;  req0_b = 5'd1; req0_ctrl = 3'b001; req0_bshift = 2'd0;
        req1_a = 5'd12; req1_b = 5'd3; req1_ctrl = 3'b010; req1_bshift = 2'd0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL contend_first: req_ready=%b want 01", req_ready);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_result !== 5'd6 || rsp_flags !== 4'b0010) begin
            errors++;
            $display("FAIL contend_rsp0: rv=%b res=%0d fl=%b want 01 6 0010", rsp_valid, rsp_result, rsp_flags);
        end
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL contend_second: req_ready=%b want 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_result !== 5'd0 || rsp_flags !== 4'b0100) begin
            errors++;
            $display("FAIL contend_rsp1: rv=%b res=%0d fl=%b want 10 0 0100", rsp_valid, rsp_result, rsp_flags);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int n_acc = 0;
        int last_cyc = 0;
        req0_a = 5'd1; req0_b = 5'd0; req0_ctrl = 3'b011; req0_bshift = 2'd0;
        req1_a = 5'd2; req1_b = 5'd0; req1_ctrl = 3'b011; req1_bshift = 2'd0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int cyc = 0; cyc < 40 && n_acc < 6; cyc++) begin
            #1;
            if (rsp_valid != 2'b00) begin
                checks++;
                if (rsp_result !== (rsp_valid[1] ? 5'd2 : 5'd1)) begin
                    errors++; $display("FAIL fair_result: rv=%b res=%0d", rsp_valid, rsp_result);
                end
            end
            if ((req_valid & req_ready) != 2'b00) begin
                checks++;
                if (req_ready !== ((n_acc % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL fair_order: op %0d req_ready=%b", n_acc, req_ready);
                end
                if (n_acc > 0) begin
                    checks++;
                    if (cyc - last_cyc !== 3) begin
                        errors++; $display("FAIL fair_interval: op %0d gap=%0d want 3", n_acc, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n_acc++;
            end
            @(negedge clk);
        end
        checks++;
        if (n_acc !== 6) begin
            errors++; $display("FAIL fair_timeout: accepts=%0d want 6", n_acc);
        end
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        req0_a = 5'd31; req0_b = 5'd1; req0_ctrl = 3'b000; req0_bshift = 2'd0;
        req1_a = 5'd4;  req1_b = 5'd4; req1_ctrl = 3'b000; req1_bshift = 2'd0;
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 2'b01 || rsp_result !== 5'd0 || rsp_flags !== 4'b0110 ||
                alu_a !== 5'd31 || alu_b !== 5'd1 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold: cyc %0d rv=%b res=%0d fl=%b a=%0d b=%0d rr=%b", i,
                         rsp_valid, rsp_result, rsp_flags, alu_a, alu_b, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 2'b01;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
            errors++; $display("FAIL bp_release: rv=%b rr=%b want 00 10", rsp_valid, req_ready);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        req0_a = 5'd6; req0_b = 5'd6; req0_ctrl = 3'b000; req0_bshift = 2'd0;
        rsp_ready = 2'b01;
        req_valid = 2'b01;
        @(negedge clk);                   // EXEC
        req_valid = 2'b00;
        reset_n   = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_ctrl, alu_bshift, rsp_result, rsp_flags, rsp_valid} !== 26'd0) begin
            errors++;
            $display("FAIL midreset_zero: a=%0d b=%0d rv=%b res=%0d", alu_a, alu_b, rsp_valid, rsp_result);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 2'b00) begin
                errors++; $display("FAIL midreset_norsp: cyc %0d rv=%b want 00", i, rsp_valid);
            end
        end
        req0_a = 5'd4; req0_b = 5'd4; req0_ctrl = 3'b001;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL midreset_pref0: req_ready=%b want 01", req_ready);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_result !== 5'd0 || rsp_flags !== 4'b0110) begin
            errors++;
            $display("FAIL midreset_next: rv=%b res=%0d fl=%b want 01 0 0110", rsp_valid, rsp_result, rsp_flags);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_non_owner_ready();
        req1_a = 5'd9; req1_b = 5'd2; req1_ctrl = 3'b100; req1_bshift = 2'd2;
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL nonown_grant: req_ready=%b want 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_result !== 5'd1 || rsp_flags !== 4'b0000) begin
            errors++;
            $display("FAIL nonown_resp: rv=%b res=%0d fl=%b want 10 1 0000", rsp_valid, rsp_result, rsp_flags);
        end
        rsp_ready = 2'b01;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_result !== 5'd1) begin
            errors++; $display("FAIL nonown_ignored: rv=%b res=%0d want 10 1", rsp_valid, rsp_result);
        end
        rsp_ready = 2'b10;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL nonown_done: rv=%b want 00", rsp_valid);
        end
        rsp_ready = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_mid_op();
        test_non_owner_ready();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
